fd_multiciclo: RTL and testbench

Parametrised multicycle datapath for the RV64I-subset processor. It is the successor to the single-cycle datapath. Every architectural intermediate is held in a clocked staging register: PC, IR, old-PC, A, B, ALUOut, MDR and flags. One instruction therefore takes 3–5 clocks under an external control unit. It sits between the instruction/data memories and the control unit, exposes `opcode`/`funct3`/`alu_flags` to the control unit, and takes all write enables and mux selects from it.

---
 rtl/fd_multiciclo_if.sv | 33 +++
 rtl/fd_multiciclo.sv | 151 +++++++++++++++
 tb/tb_fd_multiciclo.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fd_multiciclo_if.sv
// Control-unit and memory bus of the multicycle datapath. The control unit and memories
// take the master side; the datapath takes the slave side.
interface fd_multiciclo_if #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned i_addr_bits = 6,
  parameter int unsigned d_addr_bits = 6
);
  logic                   ir_we;
  logic                   pc_we;
  logic                   pc_src;
  logic                   rf_we;
  logic                   rf_src;
  logic                   alu_src;
  logic [3:0]             alu_cmd;
  logic [6:0]             opcode;
  logic [2:0]             funct3;
  logic [3:0]             alu_flags;
  logic [i_addr_bits-1:0] i_mem_addr;
  logic [31:0]            i_mem_data;
  logic [d_addr_bits-1:0] d_mem_addr;
  logic [XLEN-1:0]        d_mem_wdata;
  logic [XLEN-1:0]        d_mem_rdata;

  modport master (
    output ir_we, pc_we, pc_src, rf_we, rf_src, alu_src, alu_cmd, i_mem_data, d_mem_rdata,
    input  opcode, funct3, alu_flags, i_mem_addr, d_mem_addr, d_mem_wdata
  );

  modport slave (
    input  ir_we, pc_we, pc_src, rf_we, rf_src, alu_src, alu_cmd, i_mem_data, d_mem_rdata,
    output opcode, funct3, alu_flags, i_mem_addr, d_mem_addr, d_mem_wdata
  );
endinterface

// File: rtl/fd_multiciclo.sv
// Multicycle RV64I-subset datapath: PC, IR, old-PC, A, B, ALUOut, MDR and flags are staged.
// Define FD_MULTICICLO_BYPASS_EN to forward the write-back value into A/B on a same-edge read.
module fd_multiciclo #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned REG_COUNT   = 32,
  parameter int unsigned i_addr_bits = 6,
  parameter int unsigned d_addr_bits = 6
) (
  input logic            clk,
  input logic            rst_n,
  fd_multiciclo_if.slave bus
);

  localparam int unsigned RegIdxW = $clog2(REG_COUNT);
  localparam int unsigned ShW     = $clog2(XLEN);

  typedef enum logic [3:0] {
    AluAnd = 4'b0000,
    AluOr  = 4'b0001,
    AluAdd = 4'b0010,
    AluXor = 4'b0011,
    AluSll = 4'b0100,
    AluSrl = 4'b0101,
    AluSub = 4'b0110,
    AluSlt = 4'b0111
  } alu_cmd_e;

  // Staging registers
  logic [XLEN-1:0] pc_q, old_pc_q, a_q, b_q, alu_q, mdr_q;
  logic [31:0]     ir_q;
  logic [3:0]      flags_q;
  logic [XLEN-1:0] rf_q [REG_COUNT];

  // Combinational next-state
  logic [XLEN-1:0]    pc_d, a_d, b_d, imm, opb, alu_res, wb_data;
  logic [31:0]        imm32;
  logic [3:0]         flags_d;
  logic [XLEN:0]      sum, diff;
  logic               carry, ovf;
  logic [RegIdxW-1:0] rs1, rs2, rd;
  alu_cmd_e           cmd;

  assign rs1 = RegIdxW'(ir_q[19:15]);
  assign rs2 = RegIdxW'(ir_q[24:20]);
  assign rd  = RegIdxW'(ir_q[11:7]);

  // Immediate decode
  always_comb begin
    imm32 = '0;
    case (ir_q[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
      7'b0100011: imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      7'b1100011: imm32 = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      7'b1101111: imm32 = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      7'b0110111: imm32 = {ir_q[31:12], 12'b0};
      default:    imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

  // ALU
  assign opb  = bus.alu_src ? imm : b_q;
  assign sum  = {1'b0, a_q} + {1'b0, opb};
  assign diff = {1'b0, a_q} - {1'b0, opb};
  assign cmd  = alu_cmd_e'(bus.alu_cmd);

  always_comb begin
    alu_res = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    case (cmd)
      AluAnd: alu_res = a_q & opb;
      AluOr:  alu_res = a_q | opb;
      AluXor: alu_res = a_q ^ opb;
      AluAdd: begin
        alu_res = sum[XLEN-1:0];
        carry   = sum[XLEN];
        ovf     = (a_q[XLEN-1] == opb[XLEN-1]) && (sum[XLEN-1] != a_q[XLEN-1]);
      end
      AluSub: begin
        alu_res = diff[XLEN-1:0];
        // diff[XLEN] is the borrow; the flag reports its absence (A >= B unsigned)
        carry   = ~diff[XLEN];
        ovf     = (a_q[XLEN-1] != opb[XLEN-1]) && (diff[XLEN-1] != a_q[XLEN-1]);
      end
      AluSll: alu_res = a_q << opb[ShW-1:0];
      AluSrl: alu_res = a_q >> opb[ShW-1:0];
      AluSlt: alu_res = XLEN'($signed(a_q) < $signed(opb));
      default: alu_res = '0;
    endcase
  end

  assign flags_d = {carry, ovf, alu_res[XLEN-1], (alu_res == '0)};

  // PC update
  assign pc_d = bus.pc_src ? (old_pc_q + imm) : (pc_q + XLEN'(4));

  // Register read
  assign wb_data = bus.rf_src ? mdr_q : alu_q;

  always_comb begin
    a_d = (rs1 == '0) ? '0 : rf_q[rs1];
    b_d = (rs2 == '0) ? '0 : rf_q[rs2];
`ifdef FD_MULTICICLO_BYPASS_EN
    if (bus.rf_we && (rs1 != '0) && (rs1 == rd)) a_d = wb_data;
    if (bus.rf_we && (rs2 != '0) && (rs2 == rd)) b_d = wb_data;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      old_pc_q <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      mdr_q    <= '0;
      flags_q  <= '0;
    end else begin
      if (bus.pc_we) pc_q <= pc_d;
      if (bus.ir_we) begin
        ir_q     <= bus.i_mem_data;
        old_pc_q <= pc_q;
      end
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_res;
      flags_q <= flags_d;
      mdr_q   <= bus.d_mem_rdata;
    end
  end

  // Register file; x0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else if (bus.rf_we && (rd != '0)) begin
      rf_q[rd] <= wb_data;
    end
  end

  assign bus.opcode      = ir_q[6:0];
  assign bus.funct3      = ir_q[14:12];
  assign bus.alu_flags   = flags_q;
  assign bus.i_mem_addr  = pc_q[i_addr_bits-1:0];
  assign bus.d_mem_addr  = alu_q[d_addr_bits-1:0];
  assign bus.d_mem_wdata = b_q;

endmodule

// File: tb/tb_fd_multiciclo.sv
// Bench for fd_multiciclo: an architectural model checked every cycle plus directed
// literal expectations for the addi, sub, beq, ld, x0, bypass and reset scenarios.
module tb_fd_multiciclo;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  fd_multiciclo_if #(.XLEN(64), .i_addr_bits(6), .d_addr_bits(6)) bus ();

  fd_multiciclo #(
    .XLEN(64), .REG_COUNT(32), .i_addr_bits(6), .d_addr_bits(6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model
  logic [63:0] m_pc, m_opc, m_a, m_b, m_alu, m_mdr;
  logic [31:0] m_ir;
  logic [3:0]  m_fl;
  logic [63:0] m_rf [32];

  function automatic logic [63:0] f_imm(input logic [31:0] ir);
    logic [31:0] v;
    case (ir[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: v = {{20{ir[31]}}, ir[31:20]};
      7'b0100011: v = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      7'b1100011: v = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      7'b1101111: v = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      7'b0110111: v = {ir[31:12], 12'h000};
      default:    v = 32'h0;
    endcase
    return {{32{v[31]}}, v};
  endfunction

  // Returns {flags, result}; overflow = true result does not fit in 64 signed bits
  function automatic logic [67:0] f_alu(input logic [63:0] a, input logic [63:0] b,
                                        input logic [3:0] cmd);
    logic [63:0] r;
    logic        c, ov;
    logic [64:0] u;
    logic [65:0] s;
    r = 64'h0; c = 1'b0; ov = 1'b0;
    case (cmd)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd3: r = a ^ b;
      4'd2: begin
        u = {1'b0, a} + {1'b0, b};
        r = u[63:0];
        c = u[64];
        s = {{2{a[63]}}, a} + {{2{b[63]}}, b};
        ov = (s[65:63] != 3'b000) && (s[65:63] != 3'b111);
      end
      4'd6: begin
        r = a - b;
        c = (a >= b);
        s = {{2{a[63]}}, a} - {{2{b[63]}}, b};
        ov = (s[65:63] != 3'b000) && (s[65:63] != 3'b111);
      end
      4'd4: r = a << b[5:0];
      4'd5: r = a >> b[5:0];
      4'd7: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      default: r = 64'h0;
    endcase
    return {c, ov, r[63], (r == 64'h0), r};
  endfunction

  function automatic logic [63:0] f_wb();
    return bus.rf_src ? m_mdr : m_alu;
  endfunction

  function automatic logic [63:0] f_rd(input logic [4:0] idx);
    if (idx == 5'd0) return 64'h0;
`ifdef FD_MULTICICLO_BYPASS_EN
    if (bus.rf_we && idx == m_ir[11:7]) return f_wb();
`endif
    return m_rf[idx];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= '0; m_opc <= '0; m_ir <= '0; m_a <= '0; m_b <= '0;
      m_alu <= '0; m_mdr <= '0; m_fl <= '0;
      for (int i = 0; i < 32; i++) m_rf[i] <= '0;
    end else begin
      m_a <= f_rd(m_ir[19:15]);
      m_b <= f_rd(m_ir[24:20]);
      {m_fl, m_alu} <= f_alu(m_a, bus.alu_src ? f_imm(m_ir) : m_b, bus.alu_cmd);
      m_mdr <= bus.d_mem_rdata;
      if (bus.pc_we) m_pc <= bus.pc_src ? (m_opc + f_imm(m_ir)) : (m_pc + 64'd4);
      if (bus.ir_we) begin
        m_ir  <= bus.i_mem_data;
        m_opc <= m_pc;
      end
      if (bus.rf_we && m_ir[11:7] != 5'd0) m_rf[m_ir[11:7]] <= f_wb();
    end
  end

  always @(negedge clk) begin
    chk("opcode", 64'(bus.opcode), 64'(m_ir[6:0]));
    chk("funct3", 64'(bus.funct3), 64'(m_ir[14:12]));
    chk("alu_flags", 64'(bus.alu_flags), 64'(m_fl));
    chk("i_mem_addr", 64'(bus.i_mem_addr), 64'(m_pc[5:0]));
    chk("d_mem_addr", 64'(bus.d_mem_addr), 64'(m_alu[5:0]));
    chk("d_mem_wdata", bus.d_mem_wdata, m_b);
  end

  // Stimulus helpers; every task starts and ends just after a falling edge
  task automatic cyc(input logic irw, input logic pcw, input logic pcs, input logic rfw,
                     input logic rfs, input logic als, input logic [3:0] cmd);
    bus.ir_we = irw; bus.pc_we = pcw; bus.pc_src = pcs;
    bus.rf_we = rfw; bus.rf_src = rfs; bus.alu_src = als; bus.alu_cmd = cmd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] instr);
    bus.i_mem_data = instr;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
  endtask

  task automatic ex(input logic als, input logic [3:0] cmd);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, als, cmd);
  endtask

  task automatic wb(input logic rfs, input logic als, input logic [3:0] cmd);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, rfs, als, cmd);
  endtask

  task automatic peek(input logic [4:0] r, input logic [63:0] exp, input string name);
    fetch({7'd0, r, 5'd0, 3'b011, 5'd0, 7'b0100011});
    idle();
    chk(name, bus.d_mem_wdata, exp);
  endtask

  task automatic do_ld(input logic [4:0] rd, input logic [11:0] off, input logic [63:0] data,
                       input logic chk_addr);
    fetch({off, 5'd0, 3'b011, rd, 7'b0000011});
    bus.d_mem_rdata = data;
    idle();
    ex(1'b1, 4'd2);
    if (chk_addr) chk("ld_d_mem_addr", 64'(bus.d_mem_addr), 64'd8);
    ex(1'b1, 4'd2);
    wb(1'b1, 1'b1, 4'd2);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.ir_we = 1'b0; bus.pc_we = 1'b0; bus.pc_src = 1'b0; bus.rf_we = 1'b0;
    bus.rf_src = 1'b0; bus.alu_src = 1'b0; bus.alu_cmd = 4'd0;
    bus.i_mem_data = 32'h0; bus.d_mem_rdata = 64'h0;
    repeat (2) @(negedge clk);
    chk("rst_i_mem_addr", 64'(bus.i_mem_addr), 64'd0);
    chk("rst_opcode", 64'(bus.opcode), 64'd0);
    chk("rst_flags", 64'(bus.alu_flags), 64'd0);
    rst_n = 1'b1;

    // addi x1,x0,5
    fetch(32'h0050_0093);
    idle();
    ex(1'b1, 4'd2);
    wb(1'b0, 1'b1, 4'd2);
    chk("addi_i_mem_addr", 64'(bus.i_mem_addr), 64'd4);
    chk("addi_flags", 64'(bus.alu_flags), 64'h0);
    chk("addi_aluout", 64'(bus.d_mem_addr), 64'd5);
    peek(5'd1, 64'd5, "addi_x1");

    // beq x0,x0,+16 fetched at PC 8
    chk("beq_fetch_pc", 64'(bus.i_mem_addr), 64'd8);
    fetch(32'h0000_0863);
    idle();
    ex(1'b0, 4'd6);
    chk("beq_flags", 64'(bus.alu_flags), 64'b1001);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd6);
    chk("beq_target", 64'(bus.i_mem_addr), 64'd24);

    // sub x3,x1,x2 with signed overflow, then sweep every ALU command on the same operands
    do_ld(5'd1, 12'd0, 64'h8000_0000_0000_0000, 1'b0);
    do_ld(5'd2, 12'd0, 64'd1, 1'b0);
    fetch({7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011});
    idle();
    ex(1'b0, 4'd6);
    chk("sub_flags", 64'(bus.alu_flags), 64'b1100);
    chk("sub_aluout_lo", 64'(bus.d_mem_addr), 64'h3F);
    for (int c = 0; c < 16; c++) ex(1'b0, 4'(c));
    ex(1'b0, 4'd6);
    wb(1'b0, 1'b0, 4'd6);
    peek(5'd3, 64'h7FFF_FFFF_FFFF_FFFF, "sub_x3");

    // ld x4,8(x0)
    do_ld(5'd4, 12'd8, 64'hDEAD_BEEF, 1'b1);
    peek(5'd4, 64'hDEAD_BEEF, "ld_x4");
    do_ld(5'd0, 12'd0, 64'h1234, 1'b0);
    peek(5'd0, 64'd0, "x0_write");

    // ld x5,5(x0): rs2 field is x5, so B re-reads x5 on the write-back edge
    do_ld(5'd5, 12'd5, 64'd7, 1'b0);
`ifdef FD_MULTICICLO_BYPASS_EN
    chk("bypass_b", bus.d_mem_wdata, 64'd7);
`else
    chk("bypass_b", bus.d_mem_wdata, 64'd0);
`endif
    peek(5'd5, 64'd7, "ld_x5");

    // Reset asserted mid-execute
    fetch({12'd3, 5'd0, 3'b000, 5'd6, 7'b0010011});
    idle();
    bus.alu_src = 1'b1;
    bus.alu_cmd = 4'd2;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_i_mem_addr", 64'(bus.i_mem_addr), 64'd0);
    chk("rst_async_opcode", 64'(bus.opcode), 64'd0);
    chk("rst_async_funct3", 64'(bus.funct3), 64'd0);
    chk("rst_async_flags", 64'(bus.alu_flags), 64'd0);
    chk("rst_async_d_mem_addr", 64'(bus.d_mem_addr), 64'd0);
    chk("rst_async_wdata", bus.d_mem_wdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_rst_pc", 64'(bus.i_mem_addr), 64'd0);
    fetch({12'd9, 5'd0, 3'b000, 5'd7, 7'b0010011});
    chk("post_rst_fetch", 64'(bus.i_mem_addr), 64'd4);
    idle();
    peek(5'd1, 64'd0, "post_rst_x1");
    peek(5'd6, 64'd0, "post_rst_x6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
